// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer controller: cook-state encoding and width.
package microwave_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/microwave_ctrl_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter that pulses wrap on its terminal count while run is high.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic wrap
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign wrap = run && (r_count == LAST);

  // Holding (run low) keeps the phase, so a paused cook resumes mid-period.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= wrap ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cook sequencer: button edges, cook FSM, tick/load strobes, magnetron and beep.
// Define MWAVE_BEEP_EN to keep the end-of-cook beep; otherwise DONE lasts one cycle and beep is 0.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_TICKS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_btn,
  input  logic               start_btn,
  input  logic               stop_btn,
  input  logic               door_closed,
  input  logic               time_zero,
  output logic               timer_load,
  output logic               load_zero,
  output logic               timer_tick,
  output logic               mag_on,
  output logic               beep,
  output logic [STATE_W-1:0] state
);

  if (TICK_DIV < 2 || BEEP_TICKS < 1) begin : g_badParams
    $error("microwave_ctrl: TICK_DIV must be >= 2 and BEEP_TICKS >= 1");
  end

  state_t r_state;
  state_t w_nextState;
  logic   r_setQ, r_startQ, r_stopQ;
  logic   w_setEv, w_startEv, w_stopEv;
  logic   w_startCook, w_cookStay, w_enterDone;
  logic   w_clr, w_run, w_wrap;
  logic   w_load, w_loadZero, w_tick;
  logic   r_timerLoad, r_loadZero, r_timerTick, r_magOn;

  assign w_setEv   = set_btn   & ~r_setQ;
  assign w_startEv = start_btn & ~r_startQ;
  assign w_stopEv  = stop_btn  & ~r_stopQ;

  assign w_startCook = (r_state == IDLE) && !w_setEv && !w_stopEv && w_startEv
                       && door_closed && !time_zero;
  assign w_cookStay  = (r_state == COOK) && door_closed && !w_stopEv && !time_zero;
  assign w_enterDone = (r_state == COOK) && door_closed && !w_stopEv && time_zero;
  assign w_clr       = w_startCook || w_enterDone;

`ifdef MWAVE_BEEP_EN
  assign w_run = w_cookStay || (r_state == DONE);
`else
  assign w_run = w_cookStay;
`endif

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .run  (w_run),
    .wrap (w_wrap)
  );

`ifdef MWAVE_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_TICKS + 1);
  localparam logic [BEEP_W-1:0] BEEP_MAX  = BEEP_W'(BEEP_TICKS);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);

  logic [BEEP_W-1:0] r_beepCnt;
  logic              r_beep;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beepCnt <= '0;
      r_beep    <= 1'b0;
    end else begin
      r_beep <= (w_nextState == DONE);
      if (w_enterDone) begin
        r_beepCnt <= '0;
      end else if (r_state == DONE && w_wrap && r_beepCnt != BEEP_MAX) begin
        r_beepCnt <= r_beepCnt + BEEP_W'(1);
      end
    end
  end

  assign beep = r_beep;
`else
  assign beep = 1'b0;
`endif

  // Leaving COOK takes priority over the prescaler, so no tick escapes on an exit cycle.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadZero  = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setEv) begin
          w_load = 1'b1;
        end else if (w_stopEv) begin
          w_load     = 1'b1;
          w_loadZero = 1'b1;
        end else if (w_startCook) begin
          w_nextState = COOK;
        end
      end
      COOK: begin
        if (w_cookStay) begin
          w_tick = w_wrap;
        end else if (w_enterDone) begin
          w_nextState = DONE;
        end else begin
          w_nextState = PAUSE;
        end
      end
      PAUSE: begin
        if (w_stopEv) begin
          w_nextState = IDLE;
          w_load      = 1'b1;
          w_loadZero  = 1'b1;
        end else if (w_startEv && door_closed) begin
          w_nextState = COOK;
        end
      end
      DONE: begin
`ifdef MWAVE_BEEP_EN
        if (w_startEv || w_stopEv || (w_wrap && r_beepCnt == BEEP_LAST)) begin
          w_nextState = IDLE;
        end
`else
        w_nextState = IDLE;
`endif
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Button history resets high so a button held through reset raises no event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_setQ      <= 1'b1;
      r_startQ    <= 1'b1;
      r_stopQ     <= 1'b1;
      r_timerLoad <= 1'b0;
      r_loadZero  <= 1'b0;
      r_timerTick <= 1'b0;
      r_magOn     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_setQ      <= set_btn;
      r_startQ    <= start_btn;
      r_stopQ     <= stop_btn;
      r_timerLoad <= w_load;
      r_loadZero  <= w_loadZero;
      r_timerTick <= w_tick;
      r_magOn     <= (w_nextState == COOK);
    end
  end

  assign timer_load = r_timerLoad;
  assign load_zero  = r_loadZero;
  assign timer_tick = r_timerTick;
  assign mag_on     = r_magOn;
  assign state      = r_state;

endmodule
